// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_bus_pkg                                                 |
// | Brief   : CPU address map, bus-responder FSM states, DMA constants    |
// |           and the address-region decode helper.                       |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package cpu_bus_pkg;

  localparam logic [15:0] RAM_END     = 16'h1FFF;
  localparam logic [15:0] PPU_BASE    = 16'h2000;
  localparam logic [15:0] PPU_END     = 16'h3FFF;
  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam logic [15:0] PRG_BASE    = 16'h8000;

  // One alignment cycle plus a read/write pair for each of the 256 bytes.
  localparam int DMA_CYCLES = 513;
  localparam int DMA_XFERS  = (DMA_CYCLES - 1) / 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PPU_WAIT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } bus_state_t;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_PPU  = 2'd1,
    REG_PRG  = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  // Classify a 16-bit CPU address; 0x4014 falls in REG_NONE for reads.
  function automatic region_t decode_region(input logic [15:0] a);
    region_t r;
    if (a <= RAM_END)
      r = REG_RAM;
    else if ((a >= PPU_BASE) && (a <= PPU_END))
      r = REG_PPU;
    else if (a >= PRG_BASE)
      r = REG_PRG;
    else
      r = REG_NONE;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_2k.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_2k                                                      |
// | Brief   : 2048x8 single-port RAM, synchronous write, registered read. |
// |           Contents are never reset.                                   |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module ram_2k (
  input  logic        clk,
  input  logic        i_we,
  input  logic [10:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);

  logic [7:0] r_mem [0:2047];
  logic [7:0] r_rdata;

  // Write on we; read port always registers the addressed byte (old data on collision).
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_mem_responder                                           |
// | Brief   : CPU bus responder: internal RAM, PRG ROM, PPU register      |
// |           handshake and 256-byte OAM DMA engine.                      |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module cpu_mem_responder
  import cpu_bus_pkg::*;
(
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdy,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_data,
  output logic        ppu_req,
  input  logic        ppu_ack,
  output logic [2:0]  ppu_addr,
  output logic        ppu_rw,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  bus_state_t  r_state;
  bus_state_t  w_state_nxt;

  logic [7:0]  r_page;
  logic [7:0]  r_dma_cnt;
  logic [7:0]  r_dma_byte;
  logic        r_src_ram;
  logic [7:0]  r_rdata;
  logic        r_sel_ram;
  logic [2:0]  r_ppu_addr;
  logic        r_ppu_rw;
  logic [7:0]  r_ppu_wdata;

  logic        w_idle;
  region_t     w_cpu_region;
  region_t     w_dma_region;
  logic [15:0] w_dma_src;
  logic        w_ppu_hit;
  logic        w_dma_trig;
  logic        w_dma_last;
  logic        w_ram_we;
  logic [10:0] w_ram_addr;
  logic [7:0]  w_ram_q;

  assign w_idle       = (r_state == IDLE);
  assign w_cpu_region = decode_region(addr);
  assign w_dma_src    = {r_page, r_dma_cnt};
  assign w_dma_region = decode_region(w_dma_src);
  assign w_ppu_hit    = (w_cpu_region == REG_PPU);
  assign w_dma_trig   = !rw && (addr == OAMDMA_ADDR);
  assign w_dma_last   = (r_dma_cnt == 8'(DMA_XFERS - 1));

  // RAM is addressed by the DMA source only during DMA_READ; otherwise by the CPU.
  assign w_ram_addr = (r_state == DMA_READ) ? w_dma_src[10:0] : addr[10:0];
  assign w_ram_we   = rst && w_idle && !rw && (w_cpu_region == REG_RAM);
  assign prg_addr   = (r_state == DMA_READ) ? w_dma_src[14:0] : addr[14:0];

  ram_2k u_ram (
    .clk     (clk_ph1),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (wdata),
    .o_rdata (w_ram_q)
  );

  // State register; reset aborts any PPU access or DMA in flight.
  always_ff @(posedge clk_ph1) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state decode and the handshake strobes derived from the state.
  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    ppu_req     = 1'b0;
    oam_we      = 1'b0;
    case (r_state)
      IDLE: begin
        rdy = 1'b1;
        if (w_ppu_hit)
          w_state_nxt = PPU_WAIT;
        else if (w_dma_trig)
          w_state_nxt = DMA_ALIGN;
      end
      PPU_WAIT: begin
        ppu_req = 1'b1;
        if (ppu_ack)
          w_state_nxt = IDLE;
      end
      DMA_ALIGN: w_state_nxt = DMA_READ;
      DMA_READ:  w_state_nxt = DMA_WRITE;
      DMA_WRITE: begin
        oam_we      = 1'b1;
        w_state_nxt = w_dma_last ? IDLE : DMA_READ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // DMA page, byte counter and fetched byte; the counter wraps 255->0 at the end.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_page     <= 8'h00;
      r_dma_cnt  <= 8'h00;
      r_dma_byte <= 8'h00;
      r_src_ram  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dma_trig && !w_ppu_hit) begin
            r_page    <= wdata;
            r_dma_cnt <= 8'h00;
          end
        end
        DMA_READ: begin
          r_src_ram  <= (w_dma_region == REG_RAM);
          r_dma_byte <= (w_dma_region == REG_PRG) ? prg_data : 8'h00;
        end
        DMA_WRITE: begin
          r_src_ram  <= 1'b0;
          r_dma_byte <= oam_wdata;
          r_dma_cnt  <= r_dma_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // RAM data arrives through the RAM's own output register, so only a select is held.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_rdata   <= 8'h00;
      r_sel_ram <= 1'b0;
    end else if (w_idle) begin
      r_sel_ram <= 1'b0;
      r_rdata   <= rdata;
      if (rw) begin
        case (w_cpu_region)
          REG_RAM:  r_sel_ram <= 1'b1;
          REG_PRG:  r_rdata   <= prg_data;
          REG_NONE: r_rdata   <= 8'h00;
          default:  ;
        endcase
      end
    end else if ((r_state == PPU_WAIT) && ppu_ack && r_ppu_rw) begin
      r_rdata <= ppu_rdata;
    end
  end

  // Capture the PPU access fields at the request and hold them until the ack.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_ppu_addr  <= 3'd0;
      r_ppu_rw    <= 1'b1;
      r_ppu_wdata <= 8'h00;
    end else if (w_idle && w_ppu_hit) begin
      r_ppu_addr  <= addr[2:0];
      r_ppu_rw    <= rw;
      r_ppu_wdata <= wdata;
    end
  end

  assign rdata     = r_sel_ram ? w_ram_q : r_rdata;
  assign ppu_addr  = r_ppu_addr;
  assign ppu_rw    = r_ppu_rw;
  assign ppu_wdata = r_ppu_wdata;
  assign oam_addr  = r_dma_cnt;
  assign oam_wdata = ((r_state == DMA_WRITE) && r_src_ram) ? w_ram_q : r_dma_byte;

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL declare ports as follows; rst is synchronous, active-low, and the clock is clk_ph1.
- clk_ph1  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low.
- addr  in  16  CPU address bus.
- rw  in  1  1 = CPU read, 0 = CPU write.
- wdata  in  8  CPU write data.
- rdata  out  8  registered read data to CPU data bus.
- rdy  out  1  1 = CPU may advance; 0 = CPU stalled.
- prg_addr  out  15  cartridge PRG ROM address.
- prg_data  in  8  PRG ROM data, combinational from prg_addr.
- ppu_req  out  1  PPU register access request.
- ppu_ack  in  1  PPU access complete, one-cycle pulse.
- ppu_addr  out  3  PPU register index.
- ppu_rw  out  1  copy of rw for the PPU access.
- ppu_wdata  out  8  PPU write data.
- ppu_rdata  in  8  PPU read data, valid with ppu_ack.
- oam_we  out  1  OAM write strobe.
- oam_addr  out  8  OAM byte index.
- oam_wdata  out  8  OAM write data.

Function
REQ-002 SHALL decode addr when rdy=1:
- 0x0000-0x1FFF: internal RAM at addr[10:0], 2 KB mirrored x4.
- 0x2000-0x3FFF: PPU window, index addr[2:0].
- 0x4014: OAM DMA trigger.
- 0x8000-0xFFFF: PRG ROM.
- Everything else: reads return 0x00; writes are ignored.
REQ-003 RAM/PRG/unmapped read: rdata SHALL be valid one clk_ph1 after addr is presented; rdy stays 1.
REQ-004 RAM write SHALL commit wdata at the clock edge where rw=0; a read of the same location on the next cycle SHALL return the new value.
REQ-005 prg_addr SHALL equal addr[14:0] combinationally whenever the FSM is IDLE.
REQ-006 FSM states SHALL be IDLE, PPU_WAIT, DMA_ALIGN, DMA_READ, DMA_WRITE.
REQ-007 PPU access, IDLE->PPU_WAIT:
- Set ppu_req=1 and latch ppu_addr, ppu_rw and ppu_wdata.
- rdy=0 from the cycle after the access until the ack is seen.
REQ-008 PPU_WAIT completion:
- Hold ppu_req and the latched fields stable until ppu_ack=1.
- On ack: latch ppu_rdata into rdata on reads, drop ppu_req and raise rdy the next cycle, return to IDLE.
- No timeout.
REQ-009 A write to 0x4014 with value N SHALL latch page N, enter DMA_ALIGN and drive rdy=0.
REQ-010 DMA sequence:
- DMA_ALIGN lasts 1 cycle.
- Then DMA_READ/DMA_WRITE alternate 256 times.
- Source address is {N, i}, decoded per REQ-002; PPU-window sources read 0x00.
REQ-011 In DMA_WRITE: oam_we=1 for exactly one cycle, oam_addr=i, oam_wdata=the byte read in the preceding DMA_READ.
REQ-012 rdy SHALL be 0 for exactly 513 cycles per DMA and SHALL return to 1 the cycle after the i=255 write.
REQ-013 The byte counter i SHALL be 8 bits, wrapping 255->0, and DMA SHALL terminate on that wrap.
REQ-014 CPU addr/rw/wdata SHALL be ignored while rdy=0.
REQ-015 A write to 0x4014 during PPU_WAIT or DMA SHALL be impossible; no nesting is supported.
REQ-016 oam_we and ppu_req SHALL be 0 in all states other than those stated above.

Reset
REQ-017 While rst=0 at a clock edge, outputs SHALL take these values on the next cycle:
- rdata=0x00, rdy=1, ppu_req=0, oam_we=0, oam_addr=0x00, oam_wdata=0x00, ppu_addr=0, ppu_rw=1, ppu_wdata=0x00.
- FSM=IDLE, DMA counter=0.
REQ-018 Reset mid-DMA or mid-PPU access SHALL abort the operation with no further oam_we or ppu_req.
REQ-019 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-020 Shared package cpu_bus_pkg SHALL hold the address-map constants (RAM_END, PPU_BASE, PPU_END, OAMDMA_ADDR, PRG_BASE), the FSM state enum and DMA_CYCLES=513.
REQ-021 Sub-module ram_2k SHALL be used: 2048x8, single port, synchronous write, registered read.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Mirror: write 0x55 to 0x0002, then read 0x0802 -> rdata=0x55 one cycle later, rdy never 0.
- PRG read: addr 0x8000 with prg_data=0xA9 -> prg_addr=0x0000, rdata=0xA9 next cycle.
- PPU write: write 0x3F to 0x2006, ppu_ack after 3 cycles -> ppu_req=1 with ppu_addr=6, ppu_rw=0, ppu_wdata=0x3F until ack; rdy=1 the cycle after ack.
- OAM DMA: RAM 0x0200-0x02FF preloaded with value i, write 0x02 to 0x4014 -> rdy=0 for 513 cycles, 256 oam_we pulses with oam_addr=oam_wdata=i.
- Reset mid-DMA: rst=0 at DMA cycle 100 -> next cycle rdy=1, oam_we=0; a following read of 0x0200 returns its preloaded value.
- Unmapped: read 0x5000 -> rdata=0x00; write 0x6000 then read 0x0000 -> unchanged.
